// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: data-memory request/response bus between the memory
// access unit (master) and the data memory (slave). The ack is a one-cycle
// pulse; the address is always word aligned.
interface mem_access_unit_if;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic [3:0]  dmem_be;
   logic [31:0] dmem_rdata;
   logic        dmem_ack;

   modport master (
      output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
      input  dmem_rdata, dmem_ack
   );

   modport slave (
      input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
      output dmem_rdata, dmem_ack
   );
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store sequencer. Issues one word-aligned
// request per EX/MEM op, stalls the pipeline until the memory acks, then
// spends one DONE cycle so the stalled EX/MEM register can take the next op.
// Loads return the selected byte/half/word, sign- or zero-extended.
// Optional build macro MEM_MISALIGN_TRAP_EN: misaligned half/word accesses
// are not issued and raise a one-cycle misalign_err instead; without it the
// low address bits are simply truncated.
module mem_access_unit (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [3:0]               mem_read,
   input  logic [2:0]               mem_write,
   input  logic [31:0]              alu_result,
   input  logic [31:0]              read_data2,
   output logic                     busywait,
   output logic [31:0]              load_data,
   output logic                     misalign_err,
   mem_access_unit_if.master        dmem
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   state_t      state;
   logic        is_store;
   logic        op_present;
   logic        trap;
   logic        op_start;
   logic [3:0]  be_next;
   logic [31:0] wdata_next;
   logic [2:0]  ld_funct3;
   logic [1:0]  ld_off;
   logic [7:0]  lane_byte;
   logic [15:0] lane_half;
   logic [31:0] load_next;

   // A store and a load in the same slot: the store wins.
   assign is_store   = mem_write[2];
   assign op_present = mem_write[2] | mem_read[3];

`ifdef MEM_MISALIGN_TRAP_EN
   logic [1:0] acc_size;
   logic       misaligned;

   // Access size follows the op that actually executes; size 11 counts as word.
   always_comb begin
      acc_size   = is_store ? mem_write[1:0] : mem_read[1:0];
      misaligned = ((acc_size == 2'b01) && alu_result[0]) ||
                   (acc_size[1] && (alu_result[1:0] != 2'b00));
   end

   assign trap = op_present & misaligned;

   // Flag a trapped op for exactly the cycle after it was seen in IDLE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         misalign_err <= 1'b0;
      end else begin
         misalign_err <= (state == IDLE) && trap;
      end
   end
`else
   assign trap         = 1'b0;
   assign misalign_err = 1'b0;
`endif

   assign op_start = op_present & ~trap;

   // The stall must rise in the same IDLE cycle the op appears, so it is
   // combinational on the EX/MEM inputs rather than registered.
   assign busywait = ((state == IDLE) && op_start) || (state == ACCESS);

   // Store lane enables and replicated write data; loads read the whole word.
   always_comb begin
      // NOTE: defaults first so every path assigns and no latch is inferred.
      be_next    = 4'b1111;
      wdata_next = 32'h0000_0000;
      if (is_store) begin
         case (mem_write[1:0])
            2'b00: begin
               be_next    = 4'b0001 << alu_result[1:0];
               wdata_next = {4{read_data2[7:0]}};
            end
            2'b01: begin
               be_next    = alu_result[1] ? 4'b1100 : 4'b0011;
               wdata_next = {2{read_data2[15:0]}};
            end
            default: begin
               be_next    = 4'b1111;
               wdata_next = read_data2;
            end
         endcase
      end
   end

   // Select and extend the load lane from the returned word.
   always_comb begin
      lane_byte = 8'h00;
      lane_half = ld_off[1] ? dmem.dmem_rdata[31:16] : dmem.dmem_rdata[15:0];
      load_next = dmem.dmem_rdata;
      case (ld_off)
         2'b00:   lane_byte = dmem.dmem_rdata[7:0];
         2'b01:   lane_byte = dmem.dmem_rdata[15:8];
         2'b10:   lane_byte = dmem.dmem_rdata[23:16];
         default: lane_byte = dmem.dmem_rdata[31:24];
      endcase
      case (ld_funct3[1:0])
         2'b00:   load_next = {{24{lane_byte[7] & ~ld_funct3[2]}}, lane_byte};
         2'b01:   load_next = {{16{lane_half[15] & ~ld_funct3[2]}}, lane_half};
         default: load_next = dmem.dmem_rdata;
      endcase
   end

   // Sequencer: latch the request on entry to ACCESS, hold it until ack,
   // capture load data on the ack edge, then one DONE cycle back to IDLE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= IDLE;
         dmem.dmem_req   <= 1'b0;
         dmem.dmem_we    <= 1'b0;
         dmem.dmem_addr  <= 32'h0000_0000;
         dmem.dmem_wdata <= 32'h0000_0000;
         dmem.dmem_be    <= 4'b0000;
         ld_funct3       <= 3'b000;
         ld_off          <= 2'b00;
         load_data       <= 32'h0000_0000;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         case (state)
            IDLE: begin
               if (op_start) begin
                  state           <= ACCESS;
                  dmem.dmem_req   <= 1'b1;
                  dmem.dmem_we    <= is_store;
                  dmem.dmem_addr  <= {alu_result[31:2], 2'b00};
                  dmem.dmem_wdata <= wdata_next;
                  dmem.dmem_be    <= be_next;
                  ld_funct3       <= mem_read[2:0];
                  ld_off          <= alu_result[1:0];
               end
            end
            ACCESS: begin
               if (dmem.dmem_ack) begin
                  state         <= DONE;
                  dmem.dmem_req <= 1'b0;
                  if (!dmem.dmem_we) begin
                     load_data <= load_next;
                  end
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state         <= IDLE;
               dmem.dmem_req <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: self-checking bench for mem_access_unit. Directed
// vectors with hand-computed expectations, multi-cycle corner sequences,
// and random ops checked against a lane/extension model of loads and stores.
module tb_mem_access_unit;

   typedef struct {
      bit        st;
      bit        both;
      bit [2:0]  f3;
      bit [1:0]  sz;
      bit [31:0] addr;
      bit [31:0] wd;
      bit [31:0] rdata;
      int        dly;
   } op_t;

   typedef struct {
      bit [31:0] addr;
      bit [3:0]  be;
      bit        we;
      bit [31:0] wd;
      bit [31:0] ld;
   } exp_t;

   typedef struct {
      op_t  op;
      exp_t ex;
   } vec_t;

   logic        clk;
   logic        rst_n;
   logic [3:0]  mem_read;
   logic [2:0]  mem_write;
   logic [31:0] alu_result;
   logic [31:0] read_data2;
   logic        busywait;
   logic [31:0] load_data;
   logic        misalign_err;

   mem_access_unit_if dmem_bus ();

   mem_access_unit dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .mem_read     (mem_read),
      .mem_write    (mem_write),
      .alu_result   (alu_result),
      .read_data2   (read_data2),
      .busywait     (busywait),
      .load_data    (load_data),
      .misalign_err (misalign_err),
      .dmem         (dmem_bus)
   );

   int        checks = 0;
   int        failures = 0;
   int        req_pulses = 0;
   bit        req_prev = 1'b0;
   bit [31:0] exp_ld = 32'h0;
   vec_t      vecs[$];
   op_t       rops[$];
   int        gaps[$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count distinct request pulses, sampled mid-cycle.
   always @(negedge clk) begin
      if (dmem_bus.dmem_req && !req_prev) req_pulses++;
      req_prev = dmem_bus.dmem_req;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive_op(input op_t op);
      mem_write  = op.st ? {1'b1, op.sz} : 3'b000;
      mem_read   = (!op.st || op.both) ? {1'b1, op.f3} : 4'b0000;
      alu_result = op.addr;
      read_data2 = op.wd;
   endtask

   task automatic drive_idle();
      mem_write = 3'b000;
      mem_read  = 4'b0000;
   endtask

   // Reference: word address, lane enables, replicated data, extended load.
   function automatic exp_t model(input op_t op, input bit [31:0] prev_ld);
      exp_t      e;
      int        off;
      bit [31:0] b;
      bit [31:0] h;
      off    = int'(op.addr[1:0]);
      e.addr = op.addr & 32'hFFFF_FFFC;
      e.we   = op.st;
      e.ld   = prev_ld;
      e.be   = 4'hF;
      e.wd   = 32'h0;
      if (op.st) begin
         case (op.sz)
            2'd0: begin
               e.be = 4'(1 << off);
               e.wd = (op.wd & 32'hFF) * 32'h0101_0101;
            end
            2'd1: begin
               e.be = 4'(3 << (2 * int'(op.addr[1])));
               e.wd = (op.wd & 32'hFFFF) * 32'h0001_0001;
            end
            default: e.wd = op.wd;
         endcase
      end else begin
         case (op.f3[1:0])
            2'd0: begin
               b    = (op.rdata >> (8 * off)) & 32'hFF;
               e.ld = (!op.f3[2] && b >= 128) ? b - 32'd256 : b;
            end
            2'd1: begin
               h    = (op.rdata >> (16 * int'(op.addr[1]))) & 32'hFFFF;
               e.ld = (!op.f3[2] && h >= 32768) ? h - 32'd65536 : h;
            end
            default: e.ld = op.rdata;
         endcase
      end
      return e;
   endfunction

   // Runs one op whose inputs are already driven; acts as the memory, then
   // at the DONE cycle either presents the next op or idles the inputs.
   task automatic run_op(input string tag, input op_t op, input exp_t ex,
                         input bit has_next, input op_t nxt);
      int          bw;
      int          acc;
      bit          done;
      bit          stable;
      logic [31:0] a0;
      logic [31:0] w0;
      logic [3:0]  b0;
      logic        we0;
      bw = 0; acc = 0; done = 1'b0; stable = 1'b1;
      a0 = '0; w0 = '0; b0 = '0; we0 = 1'b0;
      for (int cyc = 0; cyc < 200 && !done; cyc++) begin
         @(negedge clk);
         if (dmem_bus.dmem_req) begin
            acc++;
            if (acc == 1) begin
               a0 = dmem_bus.dmem_addr; w0 = dmem_bus.dmem_wdata;
               b0 = dmem_bus.dmem_be;   we0 = dmem_bus.dmem_we;
            end else if (dmem_bus.dmem_addr !== a0 || dmem_bus.dmem_wdata !== w0 ||
                         dmem_bus.dmem_be !== b0 || dmem_bus.dmem_we !== we0) begin
               stable = 1'b0;
            end
            if (acc == op.dly) begin
               dmem_bus.dmem_ack   = 1'b1;
               dmem_bus.dmem_rdata = op.rdata;
            end
         end
         if (busywait) bw++;
         else if (!dmem_bus.dmem_req) done = 1'b1;
         if (!done) begin
            @(posedge clk); #1;
            dmem_bus.dmem_ack = 1'b0;
         end
      end
      check({tag, "_completed"}, 32'(done), 32'd1);
      check({tag, "_load_data"}, load_data, ex.ld);
      check({tag, "_misalign_err"}, 32'(misalign_err), 32'd0);
      if (has_next) drive_op(nxt);
      else drive_idle();
      check({tag, "_busy_cycles"}, 32'(bw), 32'(op.dly + 1));
      check({tag, "_req_cycles"}, 32'(acc), 32'(op.dly));
      check({tag, "_addr"}, a0, ex.addr);
      check({tag, "_be"}, 32'(b0), 32'(ex.be));
      check({tag, "_we"}, 32'(we0), 32'(ex.we));
      if (ex.we) check({tag, "_wdata"}, w0, ex.wd);
      check({tag, "_req_stable"}, 32'(stable), 32'd1);
   endtask

   initial begin
      bit [2:0] f3s [5];
      op_t      o;
      op_t      o2;
      exp_t     e;
      int       p0;
      bit       chain;

      f3s[0] = 3'b000; f3s[1] = 3'b001; f3s[2] = 3'b010; f3s[3] = 3'b100; f3s[4] = 3'b101;

      // {st,both,f3,sz,addr,wd,rdata,dly} -> {addr,be,we,wdata,load_data}
      vecs.push_back('{'{0,0,3'b010,2'd0,32'h100,32'h0,32'hDEADBEEF,3},
                       '{32'h100,4'b1111,0,32'h0,32'hDEADBEEF}});
      vecs.push_back('{'{0,0,3'b000,2'd0,32'h203,32'h0,32'h80FF1234,1},
                       '{32'h200,4'b1111,0,32'h0,32'hFFFFFF80}});
      vecs.push_back('{'{0,0,3'b100,2'd0,32'h203,32'h0,32'h80FF1234,2},
                       '{32'h200,4'b1111,0,32'h0,32'h00000080}});
      vecs.push_back('{'{1,0,3'b000,2'd1,32'h302,32'h0000ABCD,32'h0,1},
                       '{32'h300,4'b1100,1,32'hABCDABCD,32'h00000080}});
      vecs.push_back('{'{1,0,3'b000,2'd0,32'h011,32'h12345678,32'h0,2},
                       '{32'h010,4'b0010,1,32'h78787878,32'h00000080}});
      vecs.push_back('{'{0,0,3'b001,2'd0,32'h022,32'h0,32'h80017FFF,1},
                       '{32'h020,4'b1111,0,32'h0,32'hFFFF8001}});
      vecs.push_back('{'{0,0,3'b101,2'd0,32'h020,32'h0,32'h8001F00F,1},
                       '{32'h020,4'b1111,0,32'h0,32'h0000F00F}});
      vecs.push_back('{'{1,0,3'b000,2'd2,32'h044,32'hCAFEF00D,32'h0,4},
                       '{32'h044,4'b1111,1,32'hCAFEF00D,32'h0000F00F}});
      vecs.push_back('{'{0,0,3'b000,2'd0,32'h051,32'h0,32'h12345678,1},
                       '{32'h050,4'b1111,0,32'h0,32'h00000056}});
      vecs.push_back('{'{1,1,3'b010,2'd0,32'h060,32'h000000A5,32'hFFFFFFFF,1},
                       '{32'h060,4'b0001,1,32'hA5A5A5A5,32'h00000056}});
`ifndef MEM_MISALIGN_TRAP_EN
      vecs.push_back('{'{0,0,3'b001,2'd0,32'h071,32'h0,32'hAAAA5555,1},
                       '{32'h070,4'b1111,0,32'h0,32'h00005555}});
      vecs.push_back('{'{1,0,3'b000,2'd2,32'h083,32'h11223344,32'h0,2},
                       '{32'h080,4'b1111,1,32'h11223344,32'h00005555}});
      vecs.push_back('{'{1,0,3'b000,2'd1,32'h093,32'h0000BEEF,32'h0,1},
                       '{32'h090,4'b1100,1,32'hBEEFBEEF,32'h00005555}});
      vecs.push_back('{'{0,0,3'b010,2'd0,32'h0A2,32'h0,32'h0BADF00D,1},
                       '{32'h0A0,4'b1111,0,32'h0,32'h0BADF00D}});
`endif

      // Reset state, including a stray ack while held in reset.
      rst_n = 1'b0;
      drive_idle();
      alu_result = 32'h0; read_data2 = 32'h0;
      dmem_bus.dmem_ack = 1'b0; dmem_bus.dmem_rdata = 32'h0;
      #12;
      check("reset_busywait", 32'(busywait), 32'd0);
      check("reset_req", 32'(dmem_bus.dmem_req), 32'd0);
      check("reset_load_data", load_data, 32'h0);
      check("reset_misalign_err", 32'(misalign_err), 32'd0);
      dmem_bus.dmem_ack = 1'b1; dmem_bus.dmem_rdata = 32'h5A5A5A5A;
      @(posedge clk); #1;
      dmem_bus.dmem_ack = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);
      check("idle_busywait", 32'(busywait), 32'd0);
      check("idle_req", 32'(dmem_bus.dmem_req), 32'd0);
      check("idle_load_data", load_data, 32'h0);

      // Directed vectors, one op at a time.
      foreach (vecs[i]) begin
         @(posedge clk); #1;
         drive_op(vecs[i].op);
         run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].ex, 1'b0, vecs[i].op);
         exp_ld = vecs[i].ex.ld;
      end

      // Back-to-back LW then SW, next op presented during DONE.
      o  = '{0,0,3'b010,2'd0,32'h0C0,32'h0,32'h13579BDF,1};
      o2 = '{1,0,3'b000,2'd2,32'h0C4,32'h24681357,32'h0,1};
      p0 = req_pulses;
      @(posedge clk); #1;
      drive_op(o);
      e = '{32'h0C0,4'b1111,0,32'h0,32'h13579BDF};
      run_op("b2b_lw", o, e, 1'b1, o2);
      e = '{32'h0C4,4'b1111,1,32'h24681357,32'h13579BDF};
      run_op("b2b_sw", o2, e, 1'b0, o2);
      exp_ld = 32'h13579BDF;
      @(negedge clk);
      @(negedge clk);
      check("b2b_req_pulses", 32'(req_pulses - p0), 32'd2);
      check("b2b_idle_busywait", 32'(busywait), 32'd0);

      // Reset in the middle of ACCESS, then a stray ack.
      o = '{0,0,3'b010,2'd0,32'h0B0,32'h0,32'h0,1};
      @(posedge clk); #1;
      drive_op(o);
      @(posedge clk); #1;
      @(negedge clk);
      check("midrst_req_before", 32'(dmem_bus.dmem_req), 32'd1);
      rst_n = 1'b0;
      drive_idle();
      #1;
      check("midrst_req", 32'(dmem_bus.dmem_req), 32'd0);
      check("midrst_busywait", 32'(busywait), 32'd0);
      check("midrst_load_data", load_data, 32'h0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      dmem_bus.dmem_ack = 1'b1; dmem_bus.dmem_rdata = 32'hFFFFFFFF;
      @(posedge clk); #1;
      dmem_bus.dmem_ack = 1'b0;
      @(negedge clk);
      check("midrst_ack_load_data", load_data, 32'h0);
      check("midrst_ack_busywait", 32'(busywait), 32'd0);
      check("midrst_ack_req", 32'(dmem_bus.dmem_req), 32'd0);
      exp_ld = 32'h0;

`ifdef MEM_MISALIGN_TRAP_EN
      // Misaligned LW is trapped: no request, no stall, one-cycle flag.
      o = '{0,0,3'b010,2'd0,32'h101,32'h0,32'h0,1};
      @(posedge clk); #1;
      drive_op(o);
      @(negedge clk);
      check("trap_busywait", 32'(busywait), 32'd0);
      check("trap_req", 32'(dmem_bus.dmem_req), 32'd0);
      @(posedge clk); #1;
      drive_idle();
      @(negedge clk);
      check("trap_err_pulse", 32'(misalign_err), 32'd1);
      check("trap_req_after", 32'(dmem_bus.dmem_req), 32'd0);
      check("trap_busywait_after", 32'(busywait), 32'd0);
      @(negedge clk);
      check("trap_err_cleared", 32'(misalign_err), 32'd0);
      check("trap_load_data", load_data, exp_ld);
`endif

      // Random ops against the model, chained or separated by idle gaps
      // in which stray acks are thrown at the unit.
      for (int n = 0; n < 40; n++) begin
         o.st    = 1'($urandom_range(0, 1));
         o.both  = o.st && ($urandom_range(0, 3) == 0);
         o.f3    = f3s[$urandom_range(0, 4)];
         o.sz    = 2'($urandom_range(0, 2));
         o.addr  = $urandom;
         o.wd    = $urandom;
         o.rdata = $urandom;
         o.dly   = $urandom_range(1, 4);
`ifdef MEM_MISALIGN_TRAP_EN
         if ((o.st && o.sz == 2'd1) || (!o.st && o.f3[1:0] == 2'd1)) o.addr[0] = 1'b0;
         if ((o.st && o.sz == 2'd2) || (!o.st && o.f3[1:0] == 2'd2)) o.addr[1:0] = 2'b00;
`endif
         rops.push_back(o);
         gaps.push_back($urandom_range(0, 2));
      end
      @(posedge clk); #1;
      drive_op(rops[0]);
      foreach (rops[n]) begin
         chain = (n + 1 < rops.size()) && (gaps[n] == 0);
         e = model(rops[n], exp_ld);
         exp_ld = e.ld;
         run_op($sformatf("rnd%0d", n), rops[n], e, chain,
                chain ? rops[n + 1] : rops[n]);
         if (!chain && n + 1 < rops.size()) begin
            for (int g = 0; g < gaps[n]; g++) begin
               @(posedge clk); #1;
               dmem_bus.dmem_ack   = 1'($urandom_range(0, 1));
               dmem_bus.dmem_rdata = $urandom;
               @(negedge clk);
               check($sformatf("rnd%0d_gap_busywait", n), 32'(busywait), 32'd0);
               check($sformatf("rnd%0d_gap_load_data", n), load_data, exp_ld);
            end
            @(posedge clk); #1;
            dmem_bus.dmem_ack = 1'b0;
            drive_op(rops[n + 1]);
         end
      end

      // Quiet bus afterwards.
      p0 = req_pulses;
      repeat (3) @(negedge clk);
      check("final_req_pulses", 32'(req_pulses - p0), 32'd0);
      check("final_busywait", 32'(busywait), 32'd0);
      check("final_load_data", load_data, exp_ld);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
